// File: rtl/pe_sequencer_pkg.sv
// Shared CNN types for the PE_top packet interface, plus the PE sequencer FSM encoding.
package pe_sequencer_pkg;

  localparam int LANES = 4;
  localparam int DW    = 8;

  typedef enum logic [1:0] {
    INVALID = 2'd0,
    VALID   = 2'd1,
    CNN_FIN = 2'd2
  } PE_STATE;

  typedef struct packed {
    PE_STATE                    PE_state;
    logic [LANES-1:0][DW-1:0]   A;
    logic [DW-1:0]              wrb_data;
    logic [3:0]                 wrb_addr;
    logic [LANES-1:0]           wrb;
    logic [3:0]                 rdb_addr;
  } PE_IN_PACKET;

  typedef struct packed {
    PE_STATE       PE_state;
    logic [DW-1:0] data;
  } PE_OUT_PACKET;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    WAIT_RES,
    HOLD_RES
  } pe_seq_state_t;

endpackage

// File: rtl/pe_sequencer.sv
// Drives one PE_top: optional weight load, one kernel window of activations tagged
// CNN_FIN on the last tap, then captures the PE result for an upstream valid/ready port.
module pe_sequencer
  import pe_sequencer_pkg::*;
#(
  parameter int NTAP        = 9,
  parameter int RES_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     load_wt,
  input  logic [LANES-1:0]         wt_lane_mask,
  input  logic                     wt_valid,
  input  logic [DW-1:0]            wt_data,
  output logic                     wt_ready,
  input  logic                     act_valid,
  input  logic [LANES-1:0][DW-1:0] act_data,
  output logic                     act_ready,
  output PE_IN_PACKET              pe_in_pk,
  input  PE_OUT_PACKET             pe_out_pk,
  output logic                     res_valid,
  output logic [DW-1:0]            res_data,
  input  logic                     res_ready,
  output logic                     busy,
  output logic                     err_timeout
);

  localparam int         TW       = (RES_TIMEOUT > 1) ? $clog2(RES_TIMEOUT) : 1;
  localparam logic [3:0] LAST_TAP = 4'(NTAP - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(RES_TIMEOUT - 1);

  pe_seq_state_t    state, state_nxt;
  logic [3:0]       tap;
  logic [TW-1:0]    to_cnt;
  logic [LANES-1:0] mask;
  logic             last_tap;
  logic             pe_fin;

  assign last_tap = (tap == LAST_TAP);
  assign pe_fin   = (pe_out_pk.PE_state == CNN_FIN);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    wt_ready  = 1'b0;
    act_ready = 1'b0;
    case (state)
      IDLE:     if (start) state_nxt = load_wt ? LOAD : RUN;
      LOAD: begin
        wt_ready = 1'b1;
        if (wt_valid && last_tap) state_nxt = RUN;
      end
      RUN: begin
        act_ready = 1'b1;
        if (act_valid && last_tap) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (pe_fin)                 state_nxt = HOLD_RES;
        else if (to_cnt == TO_LAST) state_nxt = IDLE;
      end
      HOLD_RES: if (res_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign res_valid = (state == HOLD_RES);

  // Strobe-like packet fields (wrb, PE_state) default to idle each cycle; payload fields hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      pe_in_pk    <= '0;
      tap         <= '0;
      to_cnt      <= '0;
      mask        <= '0;
      res_data    <= '0;
      err_timeout <= 1'b0;
    end else begin
      pe_in_pk.wrb      <= '0;
      pe_in_pk.PE_state <= INVALID;
      case (state)
        IDLE: begin
          if (start) begin
            mask        <= wt_lane_mask;
            err_timeout <= 1'b0;
            tap         <= '0;
          end
        end
        LOAD: begin
          if (wt_valid) begin
            pe_in_pk.wrb      <= mask;
            pe_in_pk.wrb_data <= wt_data;
            pe_in_pk.wrb_addr <= tap;
            tap               <= last_tap ? 4'd0 : tap + 4'd1;
          end
        end
        RUN: begin
          if (act_valid) begin
            pe_in_pk.A        <= act_data;
            pe_in_pk.rdb_addr <= tap;
            pe_in_pk.PE_state <= last_tap ? CNN_FIN : VALID;
            tap               <= last_tap ? 4'd0 : tap + 4'd1;
            if (last_tap) to_cnt <= '0;
          end
        end
        WAIT_RES: begin
          if (pe_fin)                 res_data    <= pe_out_pk.data;
          else if (to_cnt == TO_LAST) err_timeout <= 1'b1;
          else                        to_cnt      <= to_cnt + TW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer: expected PE packets are queued as beats are driven
// and popped one cycle later when the registered packet appears.
module tb_pe_sequencer;
  import pe_sequencer_pkg::*;

  localparam int NTAP        = 9;
  localparam int RES_TIMEOUT = 64;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic                     load_wt;
  logic [LANES-1:0]         wt_lane_mask;
  logic                     wt_valid;
  logic [DW-1:0]            wt_data;
  logic                     wt_ready;
  logic                     act_valid;
  logic [LANES-1:0][DW-1:0] act_data;
  logic                     act_ready;
  PE_IN_PACKET              pe_in_pk;
  PE_OUT_PACKET             pe_out_pk;
  logic                     res_valid;
  logic [DW-1:0]            res_data;
  logic                     res_ready;
  logic                     busy;
  logic                     err_timeout;

  pe_sequencer #(.NTAP(NTAP), .RES_TIMEOUT(RES_TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .load_wt      (load_wt),
    .wt_lane_mask (wt_lane_mask),
    .wt_valid     (wt_valid),
    .wt_data      (wt_data),
    .wt_ready     (wt_ready),
    .act_valid    (act_valid),
    .act_data     (act_data),
    .act_ready    (act_ready),
    .pe_in_pk     (pe_in_pk),
    .pe_out_pk    (pe_out_pk),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_ready    (res_ready),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  PE_IN_PACKET exp_pk;
  PE_IN_PACKET sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic got, input logic want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, want);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic chk_pk(input string tag);
    PE_IN_PACKET want;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed=%h", tag, pe_in_pk);
    end else begin
      want = sb.pop_front();
      assert (pe_in_pk === want) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, pe_in_pk, want);
      end
    end
  endtask

  // Drive one activation vector for tap t; lane i carries base + 16*i + t.
  task automatic run_beat(input int t, input logic [7:0] base, input string tag);
    act_valid = 1'b1;
    for (int i = 0; i < LANES; i++) act_data[i] = 8'(int'(base) + 16 * i + t);
    exp_pk.A        = act_data;
    exp_pk.rdb_addr = 4'(t);
    exp_pk.wrb      = '0;
    exp_pk.PE_state = (t == NTAP - 1) ? CNN_FIN : VALID;
    sb.push_back(exp_pk);
    tick();
    chk_pk(tag);
  endtask

  task automatic bubble(input string tag);
    act_valid       = 1'b0;
    exp_pk.PE_state = INVALID;
    exp_pk.wrb      = '0;
    sb.push_back(exp_pk);
    tick();
    chk_pk(tag);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; load_wt = 1'b0; wt_lane_mask = '0;
    wt_valid = 1'b0; wt_data = '0; act_valid = 1'b0; act_data = '0;
    pe_out_pk = '{PE_state: INVALID, data: 8'd0}; res_ready = 1'b0;
    exp_pk = '0;

    // Reset state
    tick(); tick();
    sb.push_back(exp_pk);
    chk_pk("reset_pk");
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_wt_ready", wt_ready, 1'b0);
    chk1("reset_act_ready", act_ready, 1'b0);
    chk1("reset_res_valid", res_valid, 1'b0);
    chk8("reset_res_data", res_data, 8'd0);
    chk1("reset_err", err_timeout, 1'b0);
    reset = 1'b0;

    // Weight load: 9 back-to-back beats with full lane mask
    start = 1'b1; load_wt = 1'b1; wt_lane_mask = 4'b1111;
    tick();
    start = 1'b0; load_wt = 1'b0; wt_lane_mask = 4'b0000;
    chk1("load_wt_ready", wt_ready, 1'b1);
    chk1("load_busy", busy, 1'b1);
    for (int t = 0; t < NTAP; t++) begin
      wt_valid = 1'b1;
      wt_data  = 8'(t + 1);
      exp_pk.wrb      = 4'b1111;
      exp_pk.wrb_data = 8'(t + 1);
      exp_pk.wrb_addr = 4'(t);
      exp_pk.PE_state = INVALID;
      sb.push_back(exp_pk);
      tick();
      chk_pk("load_beat");
    end
    wt_valid = 1'b0;
    chk1("run_wt_ready", wt_ready, 1'b0);
    chk1("run_act_ready", act_ready, 1'b1);

    // Full window, no bubbles; first RUN cycle also shows wrb returning to 0
    for (int t = 0; t < NTAP; t++) run_beat(t, 8'h00, "run_beat");
    chk8("fin_a0", pe_in_pk.A[0], 8'h08);
    chk8("fin_a3", pe_in_pk.A[3], 8'h38);
    act_valid = 1'b0;
    chk1("wait_act_ready", act_ready, 1'b0);

    // Result returned three cycles after FIN, res_ready held low four cycles
    exp_pk.PE_state = INVALID;
    sb.push_back(exp_pk);
    tick();
    chk_pk("wait_invalid");
    tick();
    pe_out_pk = '{PE_state: CNN_FIN, data: 8'd204};
    tick();
    pe_out_pk = '{PE_state: CNN_FIN, data: 8'd77};
    chk1("hold_valid", res_valid, 1'b1);
    chk8("hold_data", res_data, 8'd204);
    for (int j = 0; j < 4; j++) begin
      tick();
      pe_out_pk = '{PE_state: INVALID, data: 8'd0};
      chk1("hold_valid_stall", res_valid, 1'b1);
      chk8("hold_data_stall", res_data, 8'd204);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk1("accept_res_valid", res_valid, 1'b0);
    chk1("accept_busy", busy, 1'b0);

    // Window with bubbles on taps 3 and 6, then a result that never arrives
    start = 1'b1;
    tick();
    start = 1'b0;
    chk1("bub_act_ready", act_ready, 1'b1);
    for (int t = 0; t < NTAP; t++) begin
      if (t == 3 || t == 6) begin
        bubble("bubble");
        bubble("bubble");
      end
      run_beat(t, 8'h80, "bub_beat");
    end
    act_valid = 1'b0;
    exp_pk.PE_state = INVALID;
    sb.push_back(exp_pk);
    tick();
    chk_pk("to_invalid");
    for (int j = 2; j < RES_TIMEOUT; j++) tick();
    chk1("to_err_early", err_timeout, 1'b0);
    chk1("to_busy_early", busy, 1'b1);
    tick();
    chk1("to_err_set", err_timeout, 1'b1);
    chk1("to_busy", busy, 1'b0);
    chk1("to_res_valid", res_valid, 1'b0);

    // Next start clears the sticky error
    start = 1'b1;
    tick();
    start = 1'b0;
    chk1("restart_err_clr", err_timeout, 1'b0);
    chk1("restart_busy", busy, 1'b1);

    // Start while busy is ignored; reset arriving at tap 5 clears everything
    for (int t = 0; t < 5; t++) begin
      start   = (t == 2);
      load_wt = (t == 2);
      run_beat(t, 8'h40, "rst_run_beat");
    end
    start = 1'b0; load_wt = 1'b0;
    chk1("ignored_start_busy", act_ready, 1'b1);
    reset     = 1'b1;
    act_valid = 1'b1;
    exp_pk    = '0;
    sb.push_back(exp_pk);
    tick();
    chk_pk("midreset_pk");
    chk1("midreset_busy", busy, 1'b0);
    chk1("midreset_act_ready", act_ready, 1'b0);
    chk8("midreset_res_data", res_data, 8'd0);
    reset     = 1'b0;
    act_valid = 1'b0;
    tick();
    chk1("post_reset_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
